shift_sched_64: RTL and testbench



---
 rtl/shift_pkg.sv | 38 +++
 rtl/shift_step_64.sv | 33 +++
 rtl/shift_sched_64.sv | 183 ++++++++++++++++++
 tb/tb_shift_sched_64.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants, opcode encodings and FSM state type for the iterative
// 64-bit shift scheduler.
package shift_pkg;

    localparam int XLEN = 64;
    localparam int SHW  = 6;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Index of the highest set bit; zero when no bit is set.
    function automatic logic [2:0] msb_index(input logic [SHW-1:0] r);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < SHW; i++) begin
            if (r[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] w);
        return {{(XLEN-32){w[31]}}, w[31:0]};
    endfunction

endpackage

// File: rtl/shift_step_64.sv
// One power-of-two shift stage: shifts the working value by 2^stage,
// left with zero fill or right with the supplied fill bit.
module shift_step_64
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] w_in,
    input  logic [2:0]      stage,
    input  logic            shift_left,
    input  logic            fill,
    output logic [XLEN-1:0] w_out
);

    logic [XLEN-1:0] left_s  [SHW];
    logic [XLEN-1:0] right_s [SHW];

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int S = 1 << gi;
            assign left_s[gi]  = {w_in[XLEN-1-S:0], {S{1'b0}}};
            assign right_s[gi] = {{S{fill}}, w_in[XLEN-1:S]};
        end
    endgenerate

    always_comb begin
        w_out = w_in;
        for (int i = 0; i < SHW; i++) begin
            if (stage == 3'(i)) begin
                w_out = shift_left ? left_s[i] : right_s[i];
            end
        end
    end

endmodule

// File: rtl/shift_sched_64.sv
// Two-requester round-robin front end around an iterative shifter that
// applies one power-of-two stage per cycle, highest stage first.
module shift_sched_64
    import shift_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic            req0_word,
    input  logic [XLEN-1:0] req0_din,
    input  logic [SHW-1:0]  req0_shamt,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic            req1_word,
    input  logic [XLEN-1:0] req1_din,
    input  logic [SHW-1:0]  req1_shamt,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_dout,
    output logic            rsp_err,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [XLEN-1:0] w_q, w_d;
    logic            fill_q, fill_d;
    logic [SHW-1:0]  r_q, r_d;
    logic            left_q, left_d;
    logic            word_q, word_d;
    logic            id_q, id_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            grant0, grant1, idle, accept;
    logic            sel_id, sel_word, load_fill;
    logic [1:0]      sel_op;
    logic [XLEN-1:0] sel_din, load_w, step_w;
    logic [SHW-1:0]  sel_shamt, eff_r;
    logic [2:0]      stage;

    // A lone requester wins outright; the pointer only breaks ties.
    assign grant0 = req0_valid & (~req1_valid | (ptr_q == REQ_ID0));
    assign grant1 = req1_valid & (~req0_valid | (ptr_q == REQ_ID1));
    assign idle   = (state_q == ST_IDLE);

    assign req0_ready = rst_n & idle & grant0;
    assign req1_ready = rst_n & idle & grant1;
    assign accept     = req0_ready | req1_ready;

    assign sel_id    = grant1 ? REQ_ID1 : REQ_ID0;
    assign sel_op    = grant1 ? req1_op    : req0_op;
    assign sel_word  = grant1 ? req1_word  : req0_word;
    assign sel_din   = grant1 ? req1_din   : req0_din;
    assign sel_shamt = grant1 ? req1_shamt : req0_shamt;

    // Word ops shift only by shamt[4:0].
    assign eff_r = sel_word ? {1'b0, sel_shamt[4:0]} : sel_shamt;

    always_comb begin
        load_w    = sel_din;
        load_fill = 1'b0;
        if (sel_op == OP_SRA) begin
            load_w    = sel_word ? sext_word(sel_din) : sel_din;
            load_fill = sel_word ? sel_din[31] : sel_din[XLEN-1];
        end else if (sel_word) begin
            load_w = {{(XLEN-32){1'b0}}, sel_din[31:0]};
        end
    end

    assign stage = msb_index(r_q);

    shift_step_64 u_step (
        .w_in       (w_q),
        .stage      (stage),
        .shift_left (left_q),
        .fill       (fill_q),
        .w_out      (step_w)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        fill_d  = fill_q;
        r_d     = r_q;
        left_d  = left_q;
        word_d  = word_q;
        id_d    = id_q;
        err_d   = err_q;
        dout_d  = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d   = sel_id;
                    ptr_d  = ~sel_id;
                    err_d  = 1'b0;
                    word_d = sel_word;
                    left_d = (sel_op == OP_SLL);
                    fill_d = load_fill;
                    w_d    = load_w;
                    r_d    = eff_r;
                    if (sel_op == OP_ILL) begin
                        err_d   = 1'b1;
                        word_d  = 1'b0;
                        w_d     = sel_din;
                        r_d     = '0;
                        dout_d  = sel_din;
                        state_d = ST_DONE;
                    end else if (eff_r == '0) begin
                        dout_d  = sel_word ? sext_word(load_w) : load_w;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                w_d = step_w;
                r_d = r_q & ~(SHW'(1) << stage);
                if (r_d == '0) begin
                    dout_d  = word_q ? sext_word(step_w) : step_w;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= REQ_ID0;
            w_q     <= '0;
            fill_q  <= 1'b0;
            r_q     <= '0;
            left_q  <= 1'b0;
            word_q  <= 1'b0;
            id_q    <= REQ_ID0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            fill_q  <= fill_d;
            r_q     <= r_d;
            left_q  <= left_d;
            word_q  <= word_d;
            id_q    <= id_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_dout  = dout_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_sched_64.sv
// Self-checking bench for shift_sched_64: vector table, random ops checked
// against a reference model, arbitration/stall and mid-operation reset.
module tb_shift_sched_64;
    import shift_pkg::*;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic        word;
        logic [63:0] din;
        logic [5:0]  shamt;
        logic [63:0] exp_dout;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        id;
        logic [63:0] dout;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        req0_word = 1'b0, req1_word = 1'b0;
    logic [63:0] req0_din = '0, req1_din = '0;
    logic [5:0]  req0_shamt = '0, req1_shamt = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;
    logic [63:0] rsp_dout;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    vec_t cur_vec [2];
    exp_t sb [$];
    bit   grant_log [$];

    shift_sched_64 dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_word(req0_word), .req0_din(req0_din), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_word(req1_word), .req1_din(req1_din), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_dout(rsp_dout), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_model(input logic [1:0] op, input logic word,
                                      input logic [63:0] din, input logic [5:0] shamt,
                                      output logic [63:0] dout, output logic err, output int lat);
        logic [5:0]         r;
        logic [31:0]        y32;
        logic signed [31:0] xs32;
        logic signed [63:0] xs64;
        logic [63:0]        y64;
        r    = word ? {1'b0, shamt[4:0]} : shamt;
        lat  = 1 + $countones(r);
        err  = 1'b0;
        xs32 = din[31:0];
        xs64 = din;
        y32  = '0;
        y64  = '0;
        if (op == 2'b11) begin
            dout = din;
            err  = 1'b1;
            lat  = 1;
        end else if (word) begin
            case (op)
                2'b00:   y32 = din[31:0] << r;
                2'b01:   y32 = din[31:0] >> r;
                default: y32 = xs32 >>> r;
            endcase
            dout = {{32{y32[31]}}, y32};
        end else begin
            case (op)
                2'b00:   y64 = din << r;
                2'b01:   y64 = din >> r;
                default: y64 = xs64 >>> r;
            endcase
            dout = y64;
        end
    endfunction

    // Scoreboard monitor: push on accept, pop and compare on response handshake.
    initial begin : monitor
        bit   prev_v;
        int   first_cyc;
        exp_t e;
        prev_v    = 0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
            end else begin
                if (req0_valid && req0_ready && req1_valid && req1_ready) begin
                    chk("double_grant", 64'd1, 64'd0);
                end
                for (int r = 0; r < 2; r++) begin
                    if ((r == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                        e.id      = cur_vec[r].id;
                        e.dout    = cur_vec[r].exp_dout;
                        e.err     = cur_vec[r].exp_err;
                        e.lat     = cur_vec[r].exp_lat;
                        e.acc_cyc = cyc;
                        sb.push_back(e);
                        grant_log.push_back(r[0]);
                    end
                end
                if (rsp_valid && !prev_v) first_cyc = cyc;
                prev_v = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_dout", rsp_dout, e.dout);
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("latency", 64'(first_cyc - e.acc_cyc), 64'(e.lat));
                        $display("rsp id=%0d dout=0x%016h err=%0d lat=%0d", rsp_id, rsp_dout,
                                 rsp_err, first_cyc - e.acc_cyc);
                    end
                end
            end
        end
    end

    task automatic drive_req(input vec_t v, input bit last);
        int  n;
        bit  rdy;
        cur_vec[v.id] = v;
        if (v.id == 1'b0) begin
            req0_op = v.op; req0_word = v.word; req0_din = v.din; req0_shamt = v.shamt;
            req0_valid = 1'b1;
        end else begin
            req1_op = v.op; req1_word = v.word; req1_din = v.din; req1_shamt = v.shamt;
            req1_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = (v.id == 1'b0) ? req0_ready : req1_ready;
        end while (!rdy && n < 300);
        if (!rdy) begin
            chk("accept_timeout", 64'd0, 64'd1);
            if (v.id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (last) begin
                if (v.id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || rsp_valid) && n < 200);
        if (sb.size() != 0 || rsp_valid) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic id, input logic [1:0] op, input logic word,
                                input logic [63:0] din, input logic [5:0] shamt,
                                input logic [63:0] dout, input logic err, input int lat);
        vec_t v;
        v.id = id; v.op = op; v.word = word; v.din = din; v.shamt = shamt;
        v.exp_dout = dout; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    initial begin : stim
        vec_t tbl [11];
        vec_t v;
        int   tmo;

        tbl[0]  = mk(0, 2'b00, 0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 0, 7);
        tbl[1]  = mk(1, 2'b10, 0, 64'h8000_0000_0000_0000, 6'd4, 64'hF800_0000_0000_0000, 0, 2);
        tbl[2]  = mk(0, 2'b01, 1, 64'hFFFF_FFFF_8000_0000, 6'd0, 64'hFFFF_FFFF_8000_0000, 0, 1);
        tbl[3]  = mk(1, 2'b01, 1, 64'hFFFF_FFFF_8000_0000, 6'd63, 64'h1, 0, 6);
        tbl[4]  = mk(0, 2'b11, 1, 64'h1234, 6'd5, 64'h1234, 1, 1);
        tbl[5]  = mk(1, 2'b10, 1, 64'h0000_0000_8000_0000, 6'd4, 64'hFFFF_FFFF_F800_0000, 0, 2);
        tbl[6]  = mk(0, 2'b00, 1, 64'h0000_0000_4000_0001, 6'd1, 64'hFFFF_FFFF_8000_0002, 0, 2);
        tbl[7]  = mk(1, 2'b01, 0, 64'hF0F0_0000_0000_0000, 6'd36, 64'h0000_0000_0F0F_0000, 0, 3);
        tbl[8]  = mk(0, 2'b10, 0, 64'h7000_0000_0000_0000, 6'd60, 64'h7, 0, 5);
        tbl[9]  = mk(1, 2'b00, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 64'hFFFF_FFFF_0000_0000, 0, 2);
        tbl[10] = mk(0, 2'b10, 1, 64'hFFFF_FFFF_1234_5678, 6'd32, 64'h0000_0000_1234_5678, 0, 1);

        // Reset values, with both requesters valid to show ready is held low.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_dout", rsp_dout, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both requesters held valid, first response stalled 5 cycles.
        grant_log.delete();
        rsp_ready = 1'b0;
        fork
            begin
                drive_req(mk(0, 2'b00, 0, 64'h3, 6'd5, 64'h60, 0, 3), 0);
                drive_req(mk(0, 2'b01, 0, 64'hFF00, 6'd8, 64'hFF, 0, 2), 1);
            end
            drive_req(mk(1, 2'b10, 0, 64'h8000_0000_0000_0000, 6'd1, 64'hC000_0000_0000_0000, 0, 2), 1);
            begin
                tmo = 0;
                do begin
                    @(negedge clk);
                    tmo++;
                end while (!rsp_valid && tmo < 50);
                for (int i = 0; i < 5; i++) begin
                    chk("stall_valid", 64'(rsp_valid), 64'd1);
                    chk("stall_dout", rsp_dout, 64'h60);
                    chk("stall_id", 64'(rsp_id), 64'd0);
                    chk("stall_readys", 64'({req0_ready, req1_ready}), 64'd0);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
        chk("grant_count", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() == 3) begin
            chk("grant_order0", 64'(grant_log[0]), 64'd0);
            chk("grant_order1", 64'(grant_log[1]), 64'd1);
            chk("grant_order2", 64'(grant_log[2]), 64'd0);
        end

        for (int i = 0; i < 11; i++) begin
            drive_req(tbl[i], 1);
            wait_drain();
        end

        for (int i = 0; i < 16; i++) begin
            v.id    = i[0];
            v.op    = 2'($urandom_range(0, 3));
            v.word  = 1'($urandom_range(0, 1));
            v.din   = {$urandom, $urandom};
            v.shamt = 6'($urandom_range(0, 63));
            ref_model(v.op, v.word, v.din, v.shamt, v.exp_dout, v.exp_err, v.exp_lat);
            drive_req(v, 1);
            wait_drain();
        end

        // Reset in the middle of a long shift, preceded by a req0 grant.
        drive_req(tbl[0], 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midop_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        grant_log.delete();
        fork
            drive_req(tbl[0], 1);
            drive_req(tbl[1], 1);
            begin
                @(negedge clk);
                chk("post_rst_tie", 64'({req0_ready, req1_ready}), 64'b10);
            end
        join
        wait_drain();
        chk("post_rst_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            chk("post_rst_first", 64'(grant_log[0]), 64'd0);
            chk("post_rst_second", 64'(grant_log[1]), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
